// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring shift-subtract divide.
// Latency: fixed ITERATIONS cycles from accept to the valid_o strobe, identical for every op and special case.
// Backpressure: none downstream; upstream must hold requests while busy_o=1 (start_i is ignored outside IDLE).
module muldiv_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [2:0]               op_i,
    input  logic [DATA_WIDTH-1:0]    a_i,
    input  logic [DATA_WIDTH-1:0]    b_i,
    input  logic [ADDRESS_WIDTH-1:0] rd_i,
    input  logic                     flush_i,
    output logic                     busy_o,
    output logic                     valid_o,
    output logic [DATA_WIDTH-1:0]    result_o,
    output logic [ADDRESS_WIDTH-1:0] rd_o
);

    localparam int DW         = DATA_WIDTH;
    localparam int ITERATIONS = DATA_WIDTH;
    localparam int CNT_W      = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]         cnt_q;
    logic [2:0]               op_q;
    logic [ADDRESS_WIDTH-1:0] rd_q;
    logic [2*DW-1:0]          acc_q;      // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [DW-1:0]            mcand_q;    // mul: multiplicand magnitude; div: divisor magnitude
    logic                     neg_q;
    logic                     spec_q;
    logic [DW-1:0]            spec_val_q;
    logic [DW-1:0]            result_q;
    logic [ADDRESS_WIDTH-1:0] rd_out_q;

    logic accept;
    logic last_iter;

    // Accept-time decode
    logic            a_sgn, b_sgn;
    logic            sa, sb;
    logic [DW-1:0]   a_mag, b_mag;
    logic            neg_d;
    logic            div_zero, div_ovf;
    logic            spec_d;
    logic [DW-1:0]   spec_val_d;

    // Iteration datapath
    logic [DW:0]     mul_sum;
    logic [2*DW-1:0] mul_next;
    logic [DW:0]     rem_sh;
    logic [DW+1:0]   diff;
    logic            qbit;
    logic [2*DW-1:0] div_next;
    logic [2*DW-1:0] acc_d;

    // Final result formation
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   mul_res;
    logic [DW-1:0]   div_mag;
    logic [DW-1:0]   div_res;
    logic [DW-1:0]   fin_res;

    assign accept    = (state_q == S_IDLE) && start_i && !flush_i;
    assign last_iter = (state_q == S_CALC) && (cnt_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush always returns to IDLE, and beats start in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_CALC;
            S_CALC: begin
                if (flush_i)        state_d = S_IDLE;
                else if (last_iter) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy_o  = (state_q == S_CALC) || (state_q == S_DONE);
        valid_o = (state_q == S_DONE);
    end

    assign result_o = result_q;
    assign rd_o     = rd_out_q;

    // Operand signedness, magnitudes, result sign and special-case detection at accept
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (op_i)
            3'b000, 3'b001: begin a_sgn = 1'b1; b_sgn = 1'b1; end  // MUL, MULH
            3'b010:         begin a_sgn = 1'b1; end                // MULHSU
            3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end  // DIV, REM
            default:        begin a_sgn = 1'b0; b_sgn = 1'b0; end
        endcase
        sa    = a_sgn & a_i[DW-1];
        sb    = b_sgn & b_i[DW-1];
        a_mag = sa ? -a_i : a_i;
        b_mag = sb ? -b_i : b_i;
        // Remainder follows the dividend; every other op uses the product/quotient sign
        neg_d = (op_i[2] && op_i[1]) ? sa : (sa ^ sb);

        div_zero   = op_i[2] && (b_i == '0);
        div_ovf    = op_i[2] && !op_i[0] && (a_i == MIN_NEG) && (b_i == '1);
        spec_d     = div_zero || div_ovf;
        spec_val_d = '0;
        if (div_zero)     spec_val_d = op_i[1] ? a_i : '1;
        else if (div_ovf) spec_val_d = op_i[1] ? '0 : MIN_NEG;
    end

    // One radix-2 step of the shift-add multiplier or the restoring divider
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, acc_q[DW-1:1]};

        rem_sh   = {acc_q[2*DW-1:DW], acc_q[DW-1]};
        diff     = {1'b0, rem_sh} - {2'b00, mcand_q};
        qbit     = ~diff[DW+1];
        div_next = qbit ? {diff[DW-1:0],   acc_q[DW-2:0], 1'b1}
                        : {rem_sh[DW-1:0], acc_q[DW-2:0], 1'b0};

        acc_d    = op_q[2] ? div_next : mul_next;
    end

    // Sign fix-up and field select applied to the last iteration's output
    always_comb begin
        prod_fix = neg_q ? -acc_d : acc_d;
        mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[DW-1:0] : prod_fix[2*DW-1:DW];
        div_mag  = op_q[1] ? acc_d[2*DW-1:DW] : acc_d[DW-1:0];
        div_res  = neg_q ? -div_mag : div_mag;
        fin_res  = spec_q ? spec_val_q : (op_q[2] ? div_res : mul_res);
    end

    // Datapath: load at accept, iterate in CALC, publish result on the last iteration unless flushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            result_q   <= '0;
            rd_out_q   <= '0;
        end else if (accept) begin
            cnt_q      <= CNT_W'(ITERATIONS - 1);
            op_q       <= op_i;
            rd_q       <= rd_i;
            neg_q      <= neg_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            if (op_i[2]) begin
                acc_q   <= {{DW{1'b0}}, a_mag};
                mcand_q <= b_mag;
            end else begin
                acc_q   <= {{DW{1'b0}}, b_mag};
                mcand_q <= a_mag;
            end
        end else if (state_q == S_CALC) begin
            acc_q <= acc_d;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            if (last_iter && !flush_i) begin
                result_q <= fin_res;
                rd_out_q <= rd_q;
            end
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly upstream of the register file write port.
- Consumes the two register-file read operands (RD1/RD2) and produces a 32-bit result plus destination register for writeback (WD3/AD3/WE3).
- Fixed-latency radix-2 engine: one shift-add or shift-subtract iteration per cycle. The control unit stalls on busy_o.

Parameters:
DATA_WIDTH, 32, operand/result width
ADDRESS_WIDTH, 5, destination register index width
ITERATIONS, DATA_WIDTH, iteration count per operation (fixed; not independently overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  request; sampled only in IDLE
op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a_i  input  DATA_WIDTH  operand rs1 (from RD1)
b_i  input  DATA_WIDTH  operand rs2 (from RD2)
rd_i  input  ADDRESS_WIDTH  destination register index
flush_i  input  1  synchronous abort (branch/exception squash)
busy_o  output  1  high in CALC and DONE
valid_o  output  1  one-cycle result strobe (drives WE3)
result_o  output  DATA_WIDTH  result (drives WD3)
rd_o  output  ADDRESS_WIDTH  captured destination (drives AD3)

Behaviour:
- Reset: asynchronous on rst_n=0. State=IDLE, counter=0, all datapath registers=0, busy_o=0, valid_o=0, result_o=0, rd_o=0. Reset mid-operation discards the operation; no valid_o follows.
- States: IDLE, CALC, DONE.
  - IDLE -> CALC on start_i=1 and flush_i=0.
  - CALC -> DONE after ITERATIONS iterations.
  - DONE -> IDLE unconditionally after one cycle.
- Accept (edge E0):
  - Latch op_i and rd_i.
  - Latch operand magnitudes (two's-complement negate if the operand is signed for that op and negative).
  - Latch the result sign:
    - MUL/MULH: sign_a XOR sign_b.
    - MULHSU: sign_a.
    - DIV: sign_a XOR sign_b.
    - REM: sign_a.
  - Load counter = ITERATIONS-1.
- Iterations: edges E1..E32, one per edge. State is DONE after E32. valid_o=1 only in the cycle between E32 and E33. Latency is fixed at 32 cycles for every op, including special cases.
- Multiply: unsigned shift-add into a 2*DATA_WIDTH product, then conditional negate.
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
- Divide: unsigned restoring shift-subtract.
  - Quotient negated if the sign flag is set.
  - Remainder takes the dividend's sign.
- Divide by zero (b_i=0):
  - DIV/DIVU: 0xFFFFFFFF.
  - REM/REMU: a_i unchanged.
- Signed overflow (DIV/REM with a_i=0x80000000, b_i=0xFFFFFFFF):
  - DIV: 0x80000000.
  - REM: 0.
- Special cases are detected at accept. They still occupy the full latency.
- result_o and rd_o update at E32 only. They hold their value until the next completion and are not cleared by flush.
- busy_o=1 from E0 through E33.
- start_i is ignored while busy_o=1, including the DONE cycle. The next accept is possible at the first IDLE cycle.
- flush_i=1 in CALC or DONE: state to IDLE at the next edge, valid_o=0 at that edge, result_o/rd_o unchanged.
- flush_i and start_i both high in IDLE: flush wins, no accept.
- rd_i=0 completes normally with valid_o pulsed; the register file discards the x0 write.
- Operand inputs need only be stable at the accept edge.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, rd=5, accept at E0 -> busy_o high E0..E33, valid_o only after E32, result_o=0xFFFFFFEB, rd_o=5.
- MULH 0x80000000*0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; each valid exactly 32 cycles after accept.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; all fixed 32-cycle latency.
- start_i pulsed during CALC and DONE -> ignored, exactly one valid_o.
- flush_i at E10 -> busy_o low after E10, no valid_o, prior result_o retained.
- Back-to-back accept on first IDLE cycle -> second valid_o 34 cycles after the first.
- rst_n low between E15 and E16 -> busy_o, valid_o, result_o, rd_o go to 0 immediately.
- After rst_n release with start_i=0 -> IDLE, no spurious valid_o.
